// File: rtl/multi_cycle_ctr.sv
// Multi-cycle CPU control FSM: decodes opcodes into datapath strobes
// across fetch/decode/execute/memory/writeback states and counts retirements.
module multi_cycle_ctr (
    input  logic        clk,
    input  logic        rstN,
    input  logic [5:0]  opcode,
    input  logic        memReady,
    output logic [1:0]  aluOp,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        memToReg,
    output logic        regWrite,
    output logic        regDst,
    output logic [1:0]  pcSource,
    output logic [3:0]  state,
    output logic        illegalOp,
    output logic [31:0] retireCount
);
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXEC    = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQ     = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0]  r_state;
    logic [31:0] r_retire_cnt;
    logic [3:0]  w_next;
    logic        w_retire;
    logic        w_illegal;
    logic [1:0]  w_aluOp, w_aluSrcB, w_pcSource;
    logic        w_aluSrcA, w_pcWrite, w_pcWriteCond, w_iorD, w_memRead;
    logic        w_memWrite, w_irWrite, w_memToReg, w_regWrite, w_regDst;

    always_comb begin
        w_next        = FETCH;
        w_retire      = 1'b0;
        w_illegal     = 1'b0;
        w_aluOp       = 2'b00;
        w_aluSrcA     = 1'b0;
        w_aluSrcB     = 2'b00;
        w_pcSource    = 2'b00;
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_iorD        = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_memToReg    = 1'b0;
        w_regWrite    = 1'b0;
        w_regDst      = 1'b0;
        case (r_state)
            FETCH: begin
                w_memRead = 1'b1;
                w_aluSrcB = 2'b01;
                w_irWrite = memReady;
                w_pcWrite = memReady;
                w_next    = memReady ? DECODE : FETCH;
            end
            DECODE: begin
                w_aluSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYP:      w_next = EXEC;
                    OP_BEQ:       w_next = BEQ;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default: begin
                        w_next    = FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
                w_next    = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
                w_next    = memReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                w_regWrite = 1'b1;
                w_memToReg = 1'b1;
                w_retire   = 1'b1;
            end
            MEMWR: begin
                w_memWrite = 1'b1;
                w_iorD     = 1'b1;
                w_retire   = memReady;
                w_next     = memReady ? FETCH : MEMWR;
            end
            EXEC: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = 2'b10;
                w_next    = RTYPEWB;
            end
            RTYPEWB: begin
                w_regWrite = 1'b1;
                w_regDst   = 1'b1;
                w_retire   = 1'b1;
            end
            BEQ: begin
                w_aluSrcA     = 1'b1;
                w_aluOp       = 2'b01;
                w_pcWriteCond = 1'b1;
                w_pcSource    = 2'b01;
                w_retire      = 1'b1;
            end
            ADDIEX: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
                w_next    = ADDIWB;
            end
            ADDIWB: begin
                w_regWrite = 1'b1;
                w_retire   = 1'b1;
            end
            JUMP: begin
                w_pcWrite  = 1'b1;
                w_pcSource = 2'b10;
                w_retire   = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= FETCH;
            r_retire_cnt <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    // Reset gates the decoded controls so FETCH's reads never reach memory while held in reset.
    assign aluOp       = rstN ? w_aluOp       : 2'b00;
    assign aluSrcA     = rstN ? w_aluSrcA     : 1'b0;
    assign aluSrcB     = rstN ? w_aluSrcB     : 2'b00;
    assign pcSource    = rstN ? w_pcSource    : 2'b00;
    assign pcWrite     = rstN ? w_pcWrite     : 1'b0;
    assign pcWriteCond = rstN ? w_pcWriteCond : 1'b0;
    assign iorD        = rstN ? w_iorD        : 1'b0;
    assign memRead     = rstN ? w_memRead     : 1'b0;
    assign memWrite    = rstN ? w_memWrite    : 1'b0;
    assign irWrite     = rstN ? w_irWrite     : 1'b0;
    assign memToReg    = rstN ? w_memToReg    : 1'b0;
    assign regWrite    = rstN ? w_regWrite    : 1'b0;
    assign regDst      = rstN ? w_regDst      : 1'b0;
    assign illegalOp   = rstN ? w_illegal     : 1'b0;
    assign state       = r_state;
    assign retireCount = r_retire_cnt;
endmodule
